// File: rtl/uart_ram_loader_if.sv
// Bundles the loader's serial input and its RAM write / CPU control outputs.
//   rx         serial input into the loader, idle high
//   mem_load   RAM write enable, one-cycle pulse per word
//   mem_addr   RAM write address
//   mem_data   RAM write data (16 bits)
//   cpu_reset  held high while loading
//   done       image fully written, sticky until reset
//   frame_err  sticky framing-error flag
// master = loader side, slave = RAM/CPU/line side.
interface uart_ram_loader_if #(
  parameter int unsigned ADDR_WIDTH = 15
) ();
  logic                  rx;
  logic                  mem_load;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [15:0]           mem_data;
  logic                  cpu_reset;
  logic                  done;
  logic                  frame_err;

  modport master (
    input  rx,
    output mem_load, mem_addr, mem_data, cpu_reset, done, frame_err
  );

  modport slave (
    output rx,
    input  mem_load, mem_addr, mem_data, cpu_reset, done, frame_err
  );
endinterface

// File: rtl/uart_ram_loader.sv
// Boot loader: receives a length-prefixed 16-bit word image over 8N1 UART and
// writes it to RAM from address 0, holding the CPU in reset until done.
//   clk    system clock, rising edge
//   reset  synchronous active-high reset
//   bus    uart_ram_loader_if.master (rx in; mem_load/addr/data, cpu_reset,
//          done, frame_err out, all registered)
module uart_ram_loader #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned ADDR_WIDTH   = 15
) (
  input  logic clk,
  input  logic reset,
  uart_ram_loader_if.master bus
);

  localparam int unsigned TMR_W = $clog2(CLKS_PER_BIT);
  localparam logic [TMR_W-1:0] HALF_LAST = TMR_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TMR_W-1:0] FULL_LAST = TMR_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HI
  } rx_state_e;

  typedef enum logic [2:0] {
    L_CNT_HI, L_CNT_LO, L_DAT_HI, L_DAT_LO, L_DONE
  } ld_state_e;

  // Synchroniser
  logic rx_meta_q, rx_sync_q;

  // Byte receiver
  rx_state_e        rx_state_q, rx_state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             byte_valid_q, byte_valid_d;
  logic [7:0]       byte_q, byte_d;
  logic             frame_err_q, frame_err_d;

  // Frame assembler / RAM writer
  ld_state_e             ld_state_q, ld_state_d;
  logic [7:0]            hi_q, hi_d;
  logic [15:0]           count_q, count_d;
  logic [15:0]           words_q, words_d;
  logic [ADDR_WIDTH-1:0] index_q, index_d;
  logic                  mem_load_q, mem_load_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]           mem_data_q, mem_data_d;
  logic                  done_q, done_d;
  logic                  cpu_reset_q, cpu_reset_d;

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_state_q   <= RX_IDLE;
      tmr_q        <= '0;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      byte_valid_q <= 1'b0;
      byte_q       <= '0;
      frame_err_q  <= 1'b0;
      ld_state_q   <= L_CNT_HI;
      hi_q         <= '0;
      count_q      <= '0;
      words_q      <= '0;
      index_q      <= '0;
      mem_load_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      done_q       <= 1'b0;
      cpu_reset_q  <= 1'b1;
    end else begin
      rx_meta_q    <= bus.rx;
      rx_sync_q    <= rx_meta_q;
      rx_state_q   <= rx_state_d;
      tmr_q        <= tmr_d;
      bit_idx_q    <= bit_idx_d;
      shreg_q      <= shreg_d;
      byte_valid_q <= byte_valid_d;
      byte_q       <= byte_d;
      frame_err_q  <= frame_err_d;
      ld_state_q   <= ld_state_d;
      hi_q         <= hi_d;
      count_q      <= count_d;
      words_q      <= words_d;
      index_q      <= index_d;
      mem_load_q   <= mem_load_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      done_q       <= done_d;
      cpu_reset_q  <= cpu_reset_d;
    end
  end

  // Byte receiver: mid-bit sampling, LSB first, glitch and framing checks
  always_comb begin
    rx_state_d   = rx_state_q;
    tmr_d        = tmr_q + TMR_W'(1);
    bit_idx_d    = bit_idx_q;
    shreg_d      = shreg_q;
    byte_valid_d = 1'b0;
    byte_d       = byte_q;
    frame_err_d  = frame_err_q;
    unique case (rx_state_q)
      RX_IDLE: begin
        tmr_d = '0;
        if (!rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (tmr_q == HALF_LAST) begin
          tmr_d      = '0;
          bit_idx_d  = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (tmr_q == FULL_LAST) begin
          tmr_d     = '0;
          shreg_d   = {rx_sync_q, shreg_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (tmr_q == FULL_LAST) begin
          tmr_d = '0;
          if (rx_sync_q) begin
            byte_valid_d = 1'b1;
            byte_d       = shreg_q;
            rx_state_d   = RX_IDLE;
          end else begin
            frame_err_d = 1'b1;
            rx_state_d  = RX_WAIT_HI;
          end
        end
      end
      RX_WAIT_HI: begin
        // Bad stop bit: re-arm only once the line has returned high
        tmr_d = '0;
        if (rx_sync_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Frame FSM: big-endian count, then big-endian data words written to RAM
  always_comb begin
    ld_state_d  = ld_state_q;
    hi_d        = hi_q;
    count_d     = count_q;
    words_d     = words_q;
    index_d     = index_q;
    mem_load_d  = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    done_d      = (ld_state_q == L_DONE);
    cpu_reset_d = (ld_state_q != L_DONE);
    if (byte_valid_q) begin
      unique case (ld_state_q)
        L_CNT_HI: begin
          count_d    = {byte_q, count_q[7:0]};
          ld_state_d = L_CNT_LO;
        end
        L_CNT_LO: begin
          count_d    = {count_q[15:8], byte_q};
          words_d    = '0;
          index_d    = '0;
          ld_state_d = ({count_q[15:8], byte_q} == 16'd0) ? L_DONE : L_DAT_HI;
        end
        L_DAT_HI: begin
          hi_d       = byte_q;
          ld_state_d = L_DAT_LO;
        end
        L_DAT_LO: begin
          mem_load_d = 1'b1;
          mem_addr_d = index_q;
          mem_data_d = {hi_q, byte_q};
          // Address wraps naturally at ADDR_WIDTH; the word count does not
          index_d    = index_q + ADDR_WIDTH'(1);
          words_d    = words_q + 16'd1;
          ld_state_d = (words_q == count_q - 16'd1) ? L_DONE : L_DAT_HI;
        end
        L_DONE: ld_state_d = L_DONE;
        default: ld_state_d = L_CNT_HI;
      endcase
    end
  end

  assign bus.mem_load  = mem_load_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_data  = mem_data_q;
  assign bus.cpu_reset = cpu_reset_q;
  assign bus.done      = done_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_ram_loader.sv
// Directed bench for uart_ram_loader with CLKS_PER_BIT=4, ADDR_WIDTH=4.
module tb_uart_ram_loader;

  localparam int unsigned CPB = 4;
  localparam int unsigned AW  = 4;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  uart_ram_loader_if #(.ADDR_WIDTH(AW)) bus ();

  uart_ram_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write log and pulse-timing monitor, sampled on the falling edge
  logic [AW-1:0] wa[$];
  logic [15:0]   wd[$];
  int cyc, last_load_cyc, done_cyc, dbl;
  logic prev_load, prev_done;

  initial begin
    cyc = 0; last_load_cyc = -1; done_cyc = -1; dbl = 0;
    prev_load = 1'b0; prev_done = 1'b0;
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.mem_load === 1'b1) begin
      wa.push_back(bus.mem_addr);
      wd.push_back(bus.mem_data);
      last_load_cyc = cyc;
      if (prev_load) dbl = dbl + 1;
    end
    if (bus.done === 1'b1 && !prev_done) done_cyc = cyc;
    prev_load = (bus.mem_load === 1'b1);
    prev_done = (bus.done === 1'b1);
  end

  task automatic do_reset();
    bus.rx = 1'b1;
    reset  = 1'b1;
    repeat (3) @(negedge clk);
    wa.delete();
    wd.delete();
    last_load_cyc = -1;
    done_cyc      = -1;
    dbl           = 0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    bus.rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    bus.rx = stop_bit;
    repeat (CPB) @(negedge clk);
    bus.rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    repeat (100) @(negedge clk);
    vectors++;
    if (wa.size() !== 0) begin
      miscompares++; $display("FAIL reset_no_load: got %0d writes, expected 0", wa.size());
    end
    vectors++;
    if (bus.cpu_reset !== 1'b1) begin
      miscompares++; $display("FAIL reset_cpu_reset: got %b expected 1", bus.cpu_reset);
    end
    vectors++;
    if (bus.done !== 1'b0) begin
      miscompares++; $display("FAIL reset_done: got %b expected 0", bus.done);
    end
    vectors++;
    if (bus.mem_addr !== 4'h0 || bus.mem_data !== 16'h0000) begin
      miscompares++; $display("FAIL reset_addr_data: got %h/%h expected 0/0000", bus.mem_addr, bus.mem_data);
    end
    vectors++;
    if (bus.frame_err !== 1'b0) begin
      miscompares++; $display("FAIL reset_frame_err: got %b expected 0", bus.frame_err);
    end
  endtask

  task automatic test_two_words();
    do_reset();
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    vectors++;
    if (bus.done !== 1'b0 || bus.cpu_reset !== 1'b1) begin
      miscompares++; $display("FAIL two_mid_done: got done=%b cpu_reset=%b expected 0/1", bus.done, bus.cpu_reset);
    end
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    repeat (10) @(negedge clk);
    vectors++;
    if (wa.size() !== 2) begin
      miscompares++; $display("FAIL two_count: got %0d writes, expected 2", wa.size());
    end else begin
      vectors++;
      if (wa[0] !== 4'h0 || wd[0] !== 16'h1234) begin
        miscompares++; $display("FAIL two_w0: got %h@%h expected 1234@0", wd[0], wa[0]);
      end
      vectors++;
      if (wa[1] !== 4'h1 || wd[1] !== 16'hABCD) begin
        miscompares++; $display("FAIL two_w1: got %h@%h expected abcd@1", wd[1], wa[1]);
      end
    end
    vectors++;
    if (dbl !== 0) begin
      miscompares++; $display("FAIL two_pulse_width: got %0d multi-cycle pulses, expected 0", dbl);
    end
    vectors++;
    if (bus.done !== 1'b1 || bus.cpu_reset !== 1'b0) begin
      miscompares++; $display("FAIL two_done: got done=%b cpu_reset=%b expected 1/0", bus.done, bus.cpu_reset);
    end
    vectors++;
    if (done_cyc !== last_load_cyc + 1) begin
      miscompares++; $display("FAIL two_done_timing: got done cycle %0d, expected %0d", done_cyc, last_load_cyc + 1);
    end
    vectors++;
    if (bus.mem_addr !== 4'h1 || bus.mem_data !== 16'hABCD) begin
      miscompares++; $display("FAIL two_hold: got %h@%h expected abcd@1", bus.mem_data, bus.mem_addr);
    end
    vectors++;
    if (bus.frame_err !== 1'b0) begin
      miscompares++; $display("FAIL two_frame_err: got %b expected 0", bus.frame_err);
    end
    // Bytes after completion are received but must not write
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    repeat (10) @(negedge clk);
    vectors++;
    if (wa.size() !== 2 || bus.done !== 1'b1) begin
      miscompares++; $display("FAIL after_done: got %0d writes done=%b expected 2/1", wa.size(), bus.done);
    end
  endtask

  task automatic test_zero_count();
    do_reset();
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (6) @(negedge clk);
    vectors++;
    if (wa.size() !== 0) begin
      miscompares++; $display("FAIL zero_no_load: got %0d writes, expected 0", wa.size());
    end
    vectors++;
    if (bus.done !== 1'b1 || bus.cpu_reset !== 1'b0) begin
      miscompares++; $display("FAIL zero_done: got done=%b cpu_reset=%b expected 1/0", bus.done, bus.cpu_reset);
    end
    vectors++;
    if (bus.mem_addr !== 4'h0) begin
      miscompares++; $display("FAIL zero_addr: got %h expected 0", bus.mem_addr);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    bus.rx = 1'b0;
    @(negedge clk);
    bus.rx = 1'b1;
    repeat (20) @(negedge clk);
    vectors++;
    if (bus.frame_err !== 1'b0 || wa.size() !== 0) begin
      miscompares++; $display("FAIL glitch_quiet: got frame_err=%b writes=%0d expected 0/0", bus.frame_err, wa.size());
    end
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hEF, 1'b1);
    repeat (10) @(negedge clk);
    vectors++;
    if (wa.size() !== 1) begin
      miscompares++; $display("FAIL glitch_count: got %0d writes, expected 1", wa.size());
    end else begin
      vectors++;
      if (wa[0] !== 4'h0 || wd[0] !== 16'hBEEF) begin
        miscompares++; $display("FAIL glitch_w0: got %h@%h expected beef@0", wd[0], wa[0]);
      end
    end
    vectors++;
    if (bus.done !== 1'b1) begin
      miscompares++; $display("FAIL glitch_done: got %b expected 1", bus.done);
    end
  endtask

  task automatic test_frame_error();
    do_reset();
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h55, 1'b0);
    vectors++;
    if (bus.frame_err !== 1'b1) begin
      miscompares++; $display("FAIL ferr_flag: got %b expected 1", bus.frame_err);
    end
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    repeat (10) @(negedge clk);
    vectors++;
    if (wa.size() !== 1) begin
      miscompares++; $display("FAIL ferr_count: got %0d writes, expected 1", wa.size());
    end else begin
      vectors++;
      if (wa[0] !== 4'h0 || wd[0] !== 16'h1234) begin
        miscompares++; $display("FAIL ferr_w0: got %h@%h expected 1234@0", wd[0], wa[0]);
      end
    end
    vectors++;
    if (bus.done !== 1'b1 || bus.frame_err !== 1'b1) begin
      miscompares++; $display("FAIL ferr_done: got done=%b frame_err=%b expected 1/1", bus.done, bus.frame_err);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] w;
    do_reset();
    send_byte(8'h00, 1'b1);
    send_byte(8'h12, 1'b1);
    for (int i = 0; i < 18; i++) begin
      w = 16'h1000 + 16'(i);
      send_byte(w[15:8], 1'b1);
      send_byte(w[7:0], 1'b1);
    end
    repeat (10) @(negedge clk);
    vectors++;
    if (wa.size() !== 18) begin
      miscompares++; $display("FAIL wrap_count: got %0d writes, expected 18", wa.size());
    end else begin
      vectors++;
      if (wa[15] !== 4'hF || wd[15] !== 16'h100F) begin
        miscompares++; $display("FAIL wrap_w15: got %h@%h expected 100f@f", wd[15], wa[15]);
      end
      vectors++;
      if (wa[16] !== 4'h0 || wd[16] !== 16'h1010) begin
        miscompares++; $display("FAIL wrap_w16: got %h@%h expected 1010@0", wd[16], wa[16]);
      end
      vectors++;
      if (wa[17] !== 4'h1 || wd[17] !== 16'h1011) begin
        miscompares++; $display("FAIL wrap_w17: got %h@%h expected 1011@1", wd[17], wa[17]);
      end
    end
    vectors++;
    if (bus.done !== 1'b1) begin
      miscompares++; $display("FAIL wrap_done: got %b expected 1", bus.done);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'hCA, 1'b1);
    do_reset();
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'hCA, 1'b1);
    send_byte(8'hFE, 1'b1);
    repeat (10) @(negedge clk);
    vectors++;
    if (wa.size() !== 1) begin
      miscompares++; $display("FAIL midrst_count: got %0d writes, expected 1", wa.size());
    end else begin
      vectors++;
      if (wa[0] !== 4'h0 || wd[0] !== 16'hCAFE) begin
        miscompares++; $display("FAIL midrst_w0: got %h@%h expected cafe@0", wd[0], wa[0]);
      end
    end
    vectors++;
    if (bus.done !== 1'b1 || bus.cpu_reset !== 1'b0) begin
      miscompares++; $display("FAIL midrst_done: got done=%b cpu_reset=%b expected 1/0", bus.done, bus.cpu_reset);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    bus.rx      = 1'b1;
    reset       = 1'b1;
    test_reset();
    test_two_words();
    test_zero_count();
    test_glitch();
    test_frame_error();
    test_wrap();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
